// File: rtl/pw_sequencer_pkg.sv
// Shared definitions for the pulsed-wave Doppler sequencer: state codes,
// counter width (tied to the data bus width) and the default burst length.
package pw_sequencer_pkg;
  localparam int DATA_BUS_W    = 16;
  localparam int SEQ_CNT_W     = DATA_BUS_W;
  localparam int SEQ_TX_CYCLES = 8;

  typedef enum logic [2:0] {
    SEQ_IDLE   = 3'd0,
    SEQ_TX     = 3'd1,
    SEQ_DELAY1 = 3'd2,
    SEQ_DEMOD  = 3'd3,
    SEQ_GATE   = 3'd4,
    SEQ_DELAY2 = 3'd5,
    SEQ_RETX   = 3'd6
  } seq_state_e;
endpackage

// File: rtl/seq_phase_counter.sv
// Phase down-counter: loads max(v,1)-1 on state entry, decrements to zero
// and holds there. Also exposes the zero flag of the next count.
module seq_phase_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 load,
  input  logic [CNT_WIDTH-1:0] load_val,
  output logic                 zero,
  output logic                 zero_nxt
);
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load)
      cnt_nxt = (load_val == '0) ? '0 : load_val - CNT_WIDTH'(1);
    else if (cnt != '0)
      cnt_nxt = cnt - CNT_WIDTH'(1);
  end

  always_ff @(posedge CLK or posedge RST)
    if (RST) cnt <= '0;
    else     cnt <= cnt_nxt;

  assign zero     = (cnt == '0);
  assign zero_nxt = (cnt_nxt == '0);
endmodule

// File: rtl/pw_sequencer.sv
// Pulsed-wave Doppler frame sequencer: TX / DELAY1 / DEMOD / GATE / DELAY2 /
// RETX loop with registered enables that line up with the state register.
module pw_sequencer
  import pw_sequencer_pkg::*;
#(
  parameter int CNT_WIDTH  = SEQ_CNT_W,
  parameter int GATE_WIDTH = 8,
  parameter int TX_CYCLES  = SEQ_TX_CYCLES
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic                  RX_ON,
  input  logic [1:0]            TX_ON,
  input  logic [GATE_WIDTH-1:0] GATE_LENGTH,
  input  logic [CNT_WIDTH-1:0]  STATE0VALUE,
  input  logic [CNT_WIDTH-1:0]  STATE1VALUE,
  input  logic [CNT_WIDTH-1:0]  STATE2VALUE,
  input  logic [CNT_WIDTH-1:0]  STATERVALUE,
  output logic [1:0]            TX_EN,
  output logic                  RX_EN,
  output logic                  DEMOD_EN,
  output logic                  GATE_OPEN,
  output logic                  SAMPLE_STB,
  output logic                  PRF_TICK,
  output logic [2:0]            SEQ_STATE
);
  seq_state_e            state, nxt;
  logic [CNT_WIDTH-1:0]  sh_s0, sh_s1, sh_s2, sh_sr, load_val;
  logic [GATE_WIDTH-1:0] sh_gl;
  logic                  load, zero, zero_nxt;

  seq_phase_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
    .CLK(CLK), .RST(RST), .load(load), .load_val(load_val),
    .zero(zero), .zero_nxt(zero_nxt)
  );

  // ENABLE low wins over any phase advance, including on a phase's last clock.
  always_comb begin
    nxt = state;
    if (!ENABLE) nxt = SEQ_IDLE;
    else begin
      case (state)
        SEQ_IDLE:   nxt = SEQ_TX;
        SEQ_TX:     if (zero) nxt = SEQ_DELAY1;
        SEQ_DELAY1: if (zero) nxt = SEQ_DEMOD;
        SEQ_DEMOD:  if (zero) nxt = SEQ_GATE;
        SEQ_GATE:   if (zero) nxt = SEQ_DELAY2;
        SEQ_DELAY2: if (zero) nxt = SEQ_RETX;
        SEQ_RETX:   if (zero) nxt = SEQ_TX;
        default:    nxt = SEQ_IDLE;
      endcase
    end
    load = (nxt != state);
    case (nxt)
      SEQ_TX:     load_val = CNT_WIDTH'(TX_CYCLES);
      SEQ_DELAY1: load_val = sh_s0;
      SEQ_DEMOD:  load_val = sh_s1;
      SEQ_GATE:   load_val = CNT_WIDTH'(sh_gl);
      SEQ_DELAY2: load_val = sh_s2;
      SEQ_RETX:   load_val = sh_sr;
      default:    load_val = '0;
    endcase
  end

  // Outputs decode the next state so they change on the same edge as the state.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= SEQ_IDLE;
      sh_s0      <= '0;
      sh_s1      <= '0;
      sh_s2      <= '0;
      sh_sr      <= '0;
      sh_gl      <= '0;
      TX_EN      <= '0;
      RX_EN      <= 1'b0;
      DEMOD_EN   <= 1'b0;
      GATE_OPEN  <= 1'b0;
      SAMPLE_STB <= 1'b0;
      PRF_TICK   <= 1'b0;
    end else begin
      state <= nxt;
      if (nxt == SEQ_TX && state != SEQ_TX) begin
        sh_s0 <= STATE0VALUE;
        sh_s1 <= STATE1VALUE;
        sh_s2 <= STATE2VALUE;
        sh_sr <= STATERVALUE;
        sh_gl <= GATE_LENGTH;
      end
      TX_EN      <= (nxt == SEQ_TX) ? TX_ON : 2'b00;
      RX_EN      <= RX_ON && (nxt == SEQ_DEMOD || nxt == SEQ_GATE || nxt == SEQ_DELAY2);
      DEMOD_EN   <= (nxt == SEQ_DEMOD || nxt == SEQ_GATE);
      GATE_OPEN  <= (nxt == SEQ_GATE);
      SAMPLE_STB <= (nxt == SEQ_GATE) && zero_nxt;
      PRF_TICK   <= (nxt == SEQ_TX) && (state != SEQ_TX);
    end
  end

  assign SEQ_STATE = 3'(state);
endmodule

// File: tb/tb_pw_sequencer.sv
// Scoreboard bench for pw_sequencer: a frame-position model predicts every
// cycle's outputs; a monitor compares them against the DUT.
module tb_pw_sequencer;
  localparam int TXC = 8;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] tx;
    logic       rx, dm, go, stb, prf;
  } obs_t;

  logic        CLK = 0, RST = 1;
  logic        ENABLE = 0, RX_ON = 0;
  logic [1:0]  TX_ON = 0;
  logic [7:0]  GATE_LENGTH = 0;
  logic [15:0] STATE0VALUE = 0, STATE1VALUE = 0, STATE2VALUE = 0, STATERVALUE = 0;
  logic [1:0]  TX_EN;
  logic        RX_EN, DEMOD_EN, GATE_OPEN, SAMPLE_STB, PRF_TICK;
  logic [2:0]  SEQ_STATE;

  pw_sequencer #(.CNT_WIDTH(16), .GATE_WIDTH(8), .TX_CYCLES(TXC)) dut (
    .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .RX_ON(RX_ON), .TX_ON(TX_ON),
    .GATE_LENGTH(GATE_LENGTH), .STATE0VALUE(STATE0VALUE), .STATE1VALUE(STATE1VALUE),
    .STATE2VALUE(STATE2VALUE), .STATERVALUE(STATERVALUE), .TX_EN(TX_EN), .RX_EN(RX_EN),
    .DEMOD_EN(DEMOD_EN), .GATE_OPEN(GATE_OPEN), .SAMPLE_STB(SAMPLE_STB),
    .PRF_TICK(PRF_TICK), .SEQ_STATE(SEQ_STATE)
  );

  always #5 CLK = ~CLK;

  int   tests = 0, fails = 0;
  obs_t q[$];

  // stimulus values applied at the next tick
  bit        c_en, c_rx;
  bit [1:0]  c_tx;
  int        c_s0, c_s1, c_s2, c_sr, c_gl;

  // model: position in frame plus the six phase lengths captured at frame start
  bit run;
  int t, ph;
  int dur[6];

  function automatic obs_t dut_obs();
    obs_t o;
    o.st = SEQ_STATE; o.tx = TX_EN; o.rx = RX_EN; o.dm = DEMOD_EN;
    o.go = GATE_OPEN; o.stb = SAMPLE_STB; o.prf = PRF_TICK;
    return o;
  endfunction

  function automatic int atleast1(int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int period();
    int s = 0;
    for (int p = 0; p < 6; p++) s += dur[p];
    return s;
  endfunction

  task automatic capture();
    dur[0] = TXC;            dur[1] = atleast1(c_s0); dur[2] = atleast1(c_s1);
    dur[3] = atleast1(c_gl); dur[4] = atleast1(c_s2); dur[5] = atleast1(c_sr);
  endtask

  task automatic tick();
    obs_t e;
    int acc, off;
    @(negedge CLK);
    ENABLE = c_en; RX_ON = c_rx; TX_ON = c_tx;
    STATE0VALUE = 16'(c_s0); STATE1VALUE = 16'(c_s1); STATE2VALUE = 16'(c_s2);
    STATERVALUE = 16'(c_sr); GATE_LENGTH = 8'(c_gl);
    if (!c_en) run = 0;
    else if (!run) begin run = 1; t = 0; capture(); end
    else begin
      t++;
      if (t == period()) begin t = 0; capture(); end
    end
    e = '0; ph = -1; off = 0;
    if (run) begin
      acc = 0;
      for (int p = 0; p < 6; p++) begin
        if (t >= acc && t < acc + dur[p]) begin ph = p; off = t - acc; end
        acc += dur[p];
      end
      e.st  = 3'(ph + 1);
      e.tx  = (ph == 0) ? c_tx : 2'b00;
      e.rx  = c_rx && (ph >= 2 && ph <= 4);
      e.dm  = (ph == 2 || ph == 3);
      e.go  = (ph == 3);
      e.stb = (ph == 3) && (off == dur[3] - 1);
      e.prf = (t == 0);
    end
    q.push_back(e);
  endtask

  task automatic cfg(int s0, int s1, int s2, int sr, int gl, bit [1:0] tx, bit rx);
    c_s0 = s0; c_s1 = s1; c_s2 = s2; c_sr = sr; c_gl = gl; c_tx = tx; c_rx = rx;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(string name);
    obs_t o = dut_obs();
    tests++;
    if (o !== '0) begin
      fails++;
      $display("FAIL %s: got %h expected 0", name, o);
    end
  endtask

  // monitor
  initial begin
    obs_t e, o;
    forever begin
      @(posedge CLK); #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        o = dut_obs();
        tests++;
        if (o !== e) begin
          fails++;
          $display("FAIL outputs @%0t: got st=%0d tx=%b rx=%b dm=%b go=%b stb=%b prf=%b expected st=%0d tx=%b rx=%b dm=%b go=%b stb=%b prf=%b",
                   $time, o.st, o.tx, o.rx, o.dm, o.go, o.stb, o.prf,
                   e.st, e.tx, e.rx, e.dm, e.go, e.stb, e.prf);
        end
      end
    end
  end

  initial begin
    int n;
    c_en = 0; cfg(4, 3, 5, 6, 2, 2'b11, 1);
    #12 check_zero("reset_state");
    @(negedge CLK) RST = 0;
    ticks(3);

    // basic frame: period 28, RX_EN 10 clocks, one strobe
    c_en = 1; ticks(60);

    // reset asserted mid-GATE
    n = 0;
    while (!(run && ph == 3) && n < 100) begin tick(); n++; end
    @(posedge CLK); #3 RST = 1;
    #1 check_zero("async_reset_mid_gate");
    run = 0;
    @(negedge CLK) RST = 0;
    c_en = 0; ticks(4);

    // all-zero configuration: every phase one clock, period 13
    cfg(0, 0, 0, 0, 0, 2'b11, 1);
    c_en = 1; ticks(30);

    // STATE0 rewritten mid-frame only affects the next frame
    cfg(4, 3, 5, 6, 2, 2'b11, 1);
    c_en = 0; tick(); c_en = 1;
    n = 0;
    while (!(run && ph == 2) && n < 100) begin tick(); n++; end
    c_s0 = 20; ticks(70);

    // drop ENABLE during TX, then re-enable
    n = 0;
    while (!(run && ph == 0 && t == 2) && n < 100) begin tick(); n++; end
    c_en = 0; ticks(3); c_en = 1; ticks(5);

    // drop ENABLE on the last RETX clock
    n = 0;
    while (!(run && t == period() - 1) && n < 200) begin tick(); n++; end
    c_en = 0; tick(); c_en = 1; ticks(4);

    // receiver blocked, one transmit channel
    cfg(4, 3, 5, 6, 2, 2'b01, 0); ticks(60);

    // randomized stretch
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0)
        cfg($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
            $urandom_range(0, 7), $urandom_range(0, 5), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
      if ($urandom_range(0, 9) == 0) c_tx = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) c_rx = 1'($urandom_range(0, 1));
      c_en = ($urandom_range(0, 149) != 0);
      tick();
    end

    n = 0;
    while (q.size() > 0 && n < 10) begin @(posedge CLK); n++; end
    #2;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pw_sequencer.md
Name: pw_sequencer

Overview:
- Pulsed-wave Doppler timing controller. Consumes the configuration outputs of the register memory map (ENABLE, TX_ON, RX_ON, GATE_LENGTH, STATE0VALUE..STATERVALUE).
- Runs the repeating transmit / blank / demodulate / range-gate / listen / retransmit-wait frame.
- Drives transmitter enables, receiver enable, demodulator enable and the sample strobe used by the downstream Doppler datapath.

Parameters:
- CNT_WIDTH, 16: width of the phase counter and of the STATEx inputs.
- GATE_WIDTH, 8: width of GATE_LENGTH.
- TX_CYCLES, 8: transmit burst length in clocks. Must be ≥1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-high reset.
- ENABLE  in  1  sequencer run request.
- RX_ON  in  1  receiver permitted.
- TX_ON  in  2  per-channel transmit permit.
- GATE_LENGTH  in  GATE_WIDTH  range-gate length in clocks.
- STATE0VALUE  in  CNT_WIDTH  blanking delay after TX (DELAY1).
- STATE1VALUE  in  CNT_WIDTH  demodulator settle before gate (DEMOD).
- STATE2VALUE  in  CNT_WIDTH  post-gate listen (DELAY2).
- STATERVALUE  in  CNT_WIDTH  dead time before retransmit (RETX).
- TX_EN  out  2  transmitter drive enables.
- RX_EN  out  1  receiver enable.
- DEMOD_EN  out  1  demodulator enable.
- GATE_OPEN  out  1  range gate active.
- SAMPLE_STB  out  1  one-clock pulse on the last GATE clock.
- PRF_TICK  out  1  one-clock pulse on the first TX clock of each frame.
- SEQ_STATE  out  3  current state code, for debug readback.

Behaviour:
- Reset: all outputs 0; state IDLE; counter 0; shadow registers 0.
- States and codes: IDLE=0, TX=1, DELAY1=2, DEMOD=3, GATE=4, DELAY2=5, RETX=6.
- Durations in clocks:
  - TX lasts TX_CYCLES.
  - DELAY1, DEMOD, DELAY2 and RETX last their shadowed STATEx value.
  - GATE lasts the shadowed GATE_LENGTH.
  - A value of 0 is treated as 1; no state is ever skipped.
- Frame period = TX_CYCLES + sum of max(v,1) over all five phase values.
- Counter: loaded with (duration−1) on state entry and decremented each clock. The state advances on the clock where the counter equals 0.
- Sequence: TX → DELAY1 → DEMOD → GATE → DELAY2 → RETX → TX. This repeats while ENABLE=1.
- IDLE → TX on the first rising clock edge with ENABLE=1. First TX clock is one cycle after ENABLE is sampled high.
- ENABLE sampled 0 in any state → IDLE on the next edge; all outputs are 0 from that edge. Abort is immediate and frames are not completed.
- Shadowing: on every entry to TX, capture STATE0..R and GATE_LENGTH into shadow registers. Register writes during a frame take effect from the next frame only.
- TX_ON and RX_ON are not shadowed. They are live permits sampled each clock.
- Outputs are registered and reflect the current state with zero added latency:
  - TX_EN = TX_ON when in TX, else 0.
  - RX_EN = RX_ON when in DEMOD, GATE or DELAY2, else 0. It is never high in TX or DELAY1, which protects the receiver during transmit.
  - DEMOD_EN = 1 in DEMOD and GATE.
  - GATE_OPEN = 1 in GATE.
  - SAMPLE_STB = 1 on the final GATE clock.
  - PRF_TICK = 1 on the first TX clock.
- TX_ON=00 still runs full frame timing, with silent TX.
- Counter wrap: not possible, because values are at most 2^CNT_WIDTH−1 and loads are saturating.
- Simultaneous events: ENABLE falling on the last clock of a state takes priority over the state advance, so the next state is IDLE.

Decomposition:
- Shared package/defines holds:
  - state codes SEQ_IDLE..SEQ_RETX;
  - default TX_CYCLES;
  - CNT_WIDTH, which is kept consistent with the data bus width define.
- One natural sub-module, seq_phase_counter: load, decrement and zero-flag. Loads max(v,1)−1.
- The FSM and output decode stay in pw_sequencer.

Test Plan:
1. Reset asserted mid-GATE → all outputs 0 and SEQ_STATE=0 immediately (async); remains IDLE after release while ENABLE=0.
2. ENABLE=1 with TX_CYCLES=8 and STATE0..R=4,3,5,6, GATE_LENGTH=2, TX_ON=11, RX_ON=1 → PRF_TICK every 28 clocks; TX_EN=11 for 8 clocks; RX_EN high 10 clocks per frame; one SAMPLE_STB 3+1 clocks after DEMOD entry.
3. All STATEx=0 and GATE_LENGTH=0 → each phase lasts 1 clock; frame period = TX_CYCLES+5 = 13.
4. Write STATE0VALUE 4→20 during DEMOD → current frame keeps DELAY1=4; next frame DELAY1=20.
5. ENABLE dropped during TX and on the last RETX clock → IDLE next edge, TX_EN=00 and no further PRF_TICK; re-enable → PRF_TICK exactly 1 clock later.
6. RX_ON=0 and TX_ON=01 → RX_EN stays 0 for the whole frame; TX_EN=01 only during TX; frame timing unchanged.
